rr_arbiter_4: RTL and testbench

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/rr_prio_pick.sv | 34 +++
 rtl/rr_arbiter_4.sv | 102 ++++++++++
 tb/tb_rr_arbiter_4.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
// Holds the requester count, the grant-hold limit and the FSM state type.
package rr_arb_pkg;
  localparam int N            = 4;
  localparam int IDX_W        = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/rr_prio_pick.sv
// Rotated first-set-bit picker: scans vec starting at index start, with wrap-around.
// Bits set in mask are never selected.
module rr_prio_pick
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0]     cand;
  logic [IDX_W-1:0] pos;

  // The index arithmetic wraps naturally because N is a power of two.
  always_comb begin
    cand   = vec & ~mask;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int i = 0; i < N; i++) begin
      pos = start + IDX_W'(i);
      if (!found && cand[pos]) begin
        found       = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered one-hot grant.
// A bounded hold time lets other requesters preempt an owner that keeps requesting.
module rr_arbiter_4 #(
  parameter int N        = rr_arb_pkg::N,
  parameter int MAX_HOLD = rr_arb_pkg::MAX_HOLD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_vld,
  output logic [1:0]   gnt_id
);
  import rr_arb_pkg::*;

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_d;
  logic [IDX_W-1:0]  ptr, ptr_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [N-1:0]      gnt_d;
  logic [1:0]        gnt_id_d;
  logic              do_grant;

  logic [N-1:0]      pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  // Masking with the current grant excludes the owner from preemption.
  // In IDLE the grant is zero, and after a release the owner bit of req is already low.
  rr_prio_pick u_pick (
    .vec    (req),
    .start  (ptr),
    .mask   (gnt),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_d;
      gnt      <= gnt_d;
      gnt_id   <= gnt_id_d;
    end
  end

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    hold_d   = hold_cnt;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    do_grant = 1'b0;

    case (state)
      IDLE: begin
        do_grant = pick_found;
      end
      BUSY: begin
        if (req[gnt_id]) begin
          if (hold_cnt < HOLD_LAST) begin
            hold_d = hold_cnt + 1'b1;
          end else if (pick_found) begin
            do_grant = 1'b1;
          end else begin
            hold_d = '0;
          end
        end else if (pick_found) begin
          do_grant = 1'b1;
        end else begin
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_grant) begin
      state_d  = BUSY;
      gnt_d    = pick_onehot;
      gnt_id_d = pick_idx;
      ptr_d    = pick_idx + 1'b1;
      hold_d   = '0;
    end
  end

  assign gnt_vld = |gnt;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized traffic
// compared against an integer-level round-robin model.
module tb_rr_arbiter_4;
  localparam int MAX_HOLD = 8;
  localparam int STARVE_LIMIT = 3 * MAX_HOLD;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;

  int check_count;
  int pass_count;

  int m_owner;
  int m_ptr;
  int m_hold;
  int wait_cnt [4];
  int max_wait;
  logic [3:0] cur_req;
  logic       cur_rst;

  rr_arbiter_4 #(.N(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
  endtask

  function automatic int pickWinner(input logic [3:0] q, input int start, input int excl);
    for (int k = 0; k < 4; k++) begin
      int cand;
      cand = (start + k) % 4;
      if (q[cand] && cand != excl) return cand;
    end
    return -1;
  endfunction

  function automatic logic [3:0] modelGnt();
    return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  endfunction

  // Reference behaviour: one call per rising edge with the inputs present at that edge.
  task automatic modelStep(input logic r, input logic [3:0] q);
    int w;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      w = pickWinner(q, m_ptr, -1);
      if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % 4; m_hold = 0; end
    end else if (q[m_owner]) begin
      if (m_hold < MAX_HOLD - 1) m_hold++;
      else begin
        w = pickWinner(q, m_ptr, m_owner);
        if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % 4; end
        m_hold = 0;
      end
    end else begin
      w = pickWinner(q, m_ptr, m_owner);
      if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % 4; m_hold = 0; end
      else m_owner = -1;
    end
  endtask

  // Drives one cycle, advances the model and compares the registered outputs.
  task automatic applyStimulus(input logic r, input logic [3:0] q);
    logic [3:0] eg;
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    modelStep(r, q);
    #1;
    eg = modelGnt();
    checkOutput("gnt", gnt, eg);
    checkOutput("gnt_vld", gnt_vld, |eg);
    checkOutput("gnt_id", gnt_id, (m_owner < 0) ? 0 : m_owner);
    checkOutput("onehot0", $onehot0(gnt), 1);
    for (int i = 0; i < 4; i++) begin
      if (r) wait_cnt[i] = 0;
      else if (q[i] && !gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 4'b1111);
    applyStimulus(1'b1, 4'b0101);
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    m_owner = -1; m_ptr = 0; m_hold = 0;
    max_wait = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    rst = 1'b1;
    req = 4'b0000;

    doReset();
    checkOutput("reset_gnt", gnt, 4'b0000);
    checkOutput("reset_id", gnt_id, 0);
    checkOutput("reset_vld", gnt_vld, 0);
    checkOutput("reset_ptr", dut.ptr, 0);

    applyStimulus(1'b0, 4'b0101);
    checkOutput("first_gnt", gnt, 4'b0001);
    checkOutput("first_id", gnt_id, 0);
    checkOutput("first_ptr", dut.ptr, 1);
    applyStimulus(1'b0, 4'b0100);
    checkOutput("handoff_gnt", gnt, 4'b0100);
    checkOutput("handoff_ptr", dut.ptr, 3);

    doReset();
    applyStimulus(1'b0, 4'b1111);
    checkOutput("rot_gnt0", gnt, 4'b0001);
    applyStimulus(1'b0, 4'b1110);
    checkOutput("rot_gnt1", gnt, 4'b0010);
    applyStimulus(1'b0, 4'b1101);
    checkOutput("rot_gnt2", gnt, 4'b0100);
    applyStimulus(1'b0, 4'b1011);
    checkOutput("rot_gnt3", gnt, 4'b1000);
    applyStimulus(1'b0, 4'b0111);
    checkOutput("rot_wrap", gnt, 4'b0001);

    doReset();
    for (int c = 0; c < 4 * MAX_HOLD; c++) begin
      applyStimulus(1'b0, 4'b0011);
      checkOutput("preempt", gnt, ((c / MAX_HOLD) % 2 == 1) ? 4'b0010 : 4'b0001);
    end

    doReset();
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      applyStimulus(1'b0, 4'b1000);
      checkOutput("solo_gnt", gnt, 4'b1000);
      checkOutput("solo_ptr", dut.ptr, 0);
    end

    doReset();
    applyStimulus(1'b0, 4'b0100);
    checkOutput("pre_rst_gnt", gnt, 4'b0100);
    applyStimulus(1'b1, 4'b1111);
    checkOutput("mid_rst_gnt", gnt, 4'b0000);
    applyStimulus(1'b0, 4'b1111);
    checkOutput("post_rst_gnt", gnt, 4'b0001);

    cur_req = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom_range(0, 15));
      cur_rst = ($urandom_range(0, 999) == 0);
      applyStimulus(cur_rst, cur_req);
    end
    checkOutput("starvation", (max_wait > STARVE_LIMIT) ? 1 : 0, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
